// File: rtl/junction_cycle_sequencer.sv
// Cycle sequencer for one junction: steps cycle_index through fo*p/z cycles per
// sample for a latched sample count, honours stall, and emits a pipeline-aligned valid/last stream.
module junction_cycle_sequencer #(
  parameter  int p   = 16,
  parameter  int z   = 8,
  parameter  int fo  = 2,
  parameter  int L   = 2,
  localparam int CPC = fo * p / z,
  localparam int CW  = $clog2(CPC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   num_inputs,
  input  logic          stall,
  output logic [CW-1:0] cycle_index,
  output logic          cycle_valid,
  output logic          first_cycle,
  output logic          last_cycle,
  output logic [15:0]   sample_count,
  output logic          data_valid,
  output logic          data_last,
  output logic          busy,
  output logic          done
);

  localparam int DW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cycle_index_next;
  logic [15:0]   sample_count_next;
  logic [15:0]   num_latched, num_latched_next;
  logic [DW-1:0] drain_cnt, drain_cnt_next;
  logic [L-1:0]  valid_pipe, last_pipe;
  logic          at_last_index, final_sample, final_last;

  assign at_last_index = (cycle_index == CW'(CPC - 1));
  assign final_sample  = (sample_count == num_latched - 16'd1);

  // Stall gates the live strobes in the same cycle it is seen.
  assign cycle_valid = (state == RUN) && !stall;
  assign first_cycle = cycle_valid && (cycle_index == '0);
  assign last_cycle  = cycle_valid && at_last_index;
  assign final_last  = last_cycle && final_sample;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign data_valid  = valid_pipe[L-1];
  assign data_last   = last_pipe[L-1];

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next        = state;
    cycle_index_next  = cycle_index;
    sample_count_next = sample_count;
    num_latched_next  = num_latched;
    drain_cnt_next    = drain_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          num_latched_next  = num_inputs;
          cycle_index_next  = '0;
          sample_count_next = '0;
          state_next        = (num_inputs == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (at_last_index && final_sample) begin
            drain_cnt_next = DW'(L - 1);
            state_next     = DRAIN;
          end else begin
            cycle_index_next = cycle_index + CW'(1);
            if (at_last_index) sample_count_next = sample_count + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_next = DONE;
        else                 drain_cnt_next = drain_cnt - DW'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cycle_index  <= '0;
      sample_count <= '0;
      num_latched  <= '0;
      drain_cnt    <= '0;
    end else begin
      state        <= state_next;
      cycle_index  <= cycle_index_next;
      sample_count <= sample_count_next;
      num_latched  <= num_latched_next;
      drain_cnt    <= drain_cnt_next;
    end
  end

  // Models the datapath already in flight, so it keeps shifting through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= cycle_valid;
      last_pipe[0]  <= final_last;
      for (int i = 1; i < L; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_junction_cycle_sequencer.sv
// Directed bench for junction_cycle_sequencer at default parameters (CPC=4, L=2).
module tb_junction_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [15:0] num_inputs;
  logic [1:0]  cycle_index;
  logic        cycle_valid, first_cycle, last_cycle;
  logic [15:0] sample_count;
  logic        data_valid, data_last, busy, done;

  int total = 0;
  int bad   = 0;

  // Per-cycle trace, index = cycles after the start edge.
  // flags = {cycle_valid, first_cycle, last_cycle, data_valid, data_last, done, busy}
  logic [6:0] tr_flags [0:127];
  int         tr_idx   [0:127];
  int         tr_sc    [0:127];

  junction_cycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_inputs   (num_inputs),
    .stall        (stall),
    .cycle_index  (cycle_index),
    .cycle_valid  (cycle_valid),
    .first_cycle  (first_cycle),
    .last_cycle   (last_cycle),
    .sample_count (sample_count),
    .data_valid   (data_valid),
    .data_last    (data_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] flags_now();
    return {cycle_valid, first_cycle, last_cycle, data_valid, data_last, done, busy};
  endfunction

  // Launch one run; stall is high for cycles st_from..st_to, start pulses at s1/s2.
  // Returns one cycle after done, with that cycle's outputs recorded.
  task automatic run_seq(input int n, input int st_from, input int st_to,
                         input int s1, input int s2,
                         output int cv_cnt, output int dv_cnt,
                         output int done_k, output int busy_cnt);
    cv_cnt = 0; dv_cnt = 0; done_k = 0; busy_cnt = 0;
    num_inputs = 16'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      stall = (k >= st_from) && (k <= st_to);
      start = (k == s1) || (k == s2);
      #1;
      tr_flags[k] = flags_now();
      tr_idx[k]   = int'(cycle_index);
      tr_sc[k]    = int'(sample_count);
      if (cycle_valid) cv_cnt++;
      if (data_valid)  dv_cnt++;
      if (busy)        busy_cnt++;
      if (done && done_k == 0) done_k = k;
      if (done_k != 0 && k == done_k + 1) break;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(done_k != 0), 32'd1);
  endtask

  int cv, dv, dk, bc;
  int seen_done, seen_dv, seen_busy;
  logic [6:0] exp_n1 [1:8];

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; num_inputs = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {25'd0, flags_now()}, 32'd0);
    check("rst_regs", {14'd0, cycle_index, sample_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // N=1: full cycle-by-cycle trace.
    exp_n1 = '{7'b1100001, 7'b1000001, 7'b1001001, 7'b1011001,
               7'b0001001, 7'b0001101, 7'b0000011, 7'b0000000};
    run_seq(1, 0, -1, 0, 0, cv, dv, dk, bc);
    for (int k = 1; k <= 8; k++)
      check($sformatf("n1_flags_k%0d", k), {25'd0, tr_flags[k]}, {25'd0, exp_n1[k]});
    for (int k = 1; k <= 4; k++)
      check($sformatf("n1_idx_k%0d", k), tr_idx[k], k - 1);
    check("n1_done_k", dk, 7);

    // N=3, no stall.
    run_seq(3, 0, -1, 0, 0, cv, dv, dk, bc);
    check("n3_cv", cv, 12);
    check("n3_dv", dv, 12);
    check("n3_done_k", dk, 15);
    check("n3_busy", bc, 15);
    check("n3_sc_k4", tr_sc[4], 0);
    check("n3_sc_k5", tr_sc[5], 1);
    check("n3_sc_k9", tr_sc[9], 2);
    check("n3_sc_k12", tr_sc[12], 2);
    check("n3_last_k12", 32'(tr_flags[12][4]), 32'd1);

    // N=2 with stall for the three cycles starting when cycle_index first hits 2 (k=3).
    run_seq(2, 3, 5, 0, 0, cv, dv, dk, bc);
    for (int k = 3; k <= 5; k++) begin
      check($sformatf("st_idx_k%0d", k), tr_idx[k], 2);
      check($sformatf("st_cv_k%0d", k), 32'(tr_flags[k][6]), 32'd0);
    end
    check("st_resume_idx", tr_idx[6], 2);
    check("st_resume_cv", 32'(tr_flags[6][6]), 32'd1);
    check("st_cv", cv, 8);
    check("st_dv", dv, 8);
    check("st_done_k", dk, 14);

    // N=0: straight to DONE.
    run_seq(0, 0, -1, 0, 0, cv, dv, dk, bc);
    check("n0_done_k", dk, 1);
    check("n0_cv", cv, 0);
    check("n0_dv", dv, 0);
    check("n0_busy", bc, 1);

    // N=5: start pulses in RUN (k=3) and in DONE (k=23) are ignored.
    run_seq(5, 0, -1, 3, 23, cv, dv, dk, bc);
    check("rs_done_k", dk, 23);
    check("rs_cv", cv, 20);
    check("rs_idle_after", 32'(tr_flags[24][0]), 32'd0);
    // Start in the IDLE cycle after done launches a fresh run.
    run_seq(1, 0, -1, 0, 0, cv, dv, dk, bc);
    check("rs_relaunch_done_k", dk, 7);
    check("rs_relaunch_cv", cv, 4);

    // Reset mid-run while sample_count==1.
    num_inputs = 16'd5;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("mr_sc_pre", sample_count, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_flags", {25'd0, flags_now()}, 32'd0);
    check("mr_regs", {14'd0, cycle_index, sample_count}, 32'd0);
    reset = 1'b0;
    seen_done = 0; seen_dv = 0; seen_busy = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done)       seen_done++;
      if (data_valid) seen_dv++;
      if (busy)       seen_busy++;
    end
    check("mr_no_done", seen_done, 0);
    check("mr_no_dv", seen_dv, 0);
    check("mr_no_busy", seen_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/junction_cycle_sequencer.md
# junction_cycle_sequencer

Sequencer for one junction's interleaver and activation-address-decoder path. On a `start` command it steps `cycle_index` through the `fo*p/z` cycles of each input sample, for a programmed number of samples, and honours a downstream stall. It emits a valid/last stream delayed to align with the datapath pipeline, then a one-cycle `done` pulse. It sits between the network-level control FSM and the `interleaver_set` → `activation_address_decoder_set` chain.

## Interface
Parameters:
- `p`, default 16: neurons on the left side of the junction.
- `z`, default 8: degree of parallelism (edges processed per cycle).
- `fo`, default 2: fan-out.
- `L`, default 2: datapath pipeline latency in cycles. Must be ≥1.
- Derived, not overridable:
  - `CPC` = fo*p/z: cycles per sample, 4 at defaults.
  - `CW` = $clog2(CPC).
  - Legal configurations require `CPC` ≥ 2 and a power of two.

Ports (single clock; `reset` is synchronous and active-high):
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  run request. Sampled only in IDLE.
- `num_inputs`  in  16  number of samples to process. Latched on an accepted `start`.
- `stall`  in  1  downstream not ready. Freezes sequencing while high.
- `cycle_index`  out  CW  drives `interleaver_set`.
- `cycle_valid`  out  1  `cycle_index` is live this cycle.
- `first_cycle`  out  1  `cycle_valid` and `cycle_index`==0.
- `last_cycle`  out  1  `cycle_valid` and `cycle_index`==CPC-1.
- `sample_count`  out  16  index of the sample currently being sequenced.
- `data_valid`  out  1  `cycle_valid` delayed by L cycles.
- `data_last`  out  1  last cycle of the final sample, delayed by L cycles.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset drives IDLE, and every output and register goes to 0.
- IDLE:
  - `start` with `num_inputs`≠0: latch `num_inputs`, clear `cycle_index` and `sample_count`, go to RUN.
  - `start` with `num_inputs`==0: go directly to DONE.
  - Without `start`: stay in IDLE.
- RUN, `stall`=0:
  - `cycle_valid`=1.
  - `cycle_index` increments each cycle, wrapping from CPC-1 to 0.
  - On the wrap, `sample_count` increments.
  - When `cycle_index`==CPC-1 and `sample_count`==latched−1: go to DRAIN. In that final cycle `cycle_index` holds at CPC-1.
- RUN, `stall`=1:
  - `cycle_valid`=0.
  - `cycle_index` and `sample_count` hold.
  - The stall is honoured combinationally in the same cycle.
- DRAIN:
  - Lasts exactly L cycles, counted by an internal down-counter.
  - `cycle_valid`=0.
  - `stall` is ignored here.
  - Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in RUN, DRAIN and DONE; it is not queued.
- Delay line:
  - L-stage shift register carries `cycle_valid` and (`last_cycle` && final sample).
  - It keeps shifting during `stall` because it models the datapath already in flight.
  - It is cleared by reset.
- `first_cycle` and `last_cycle` are combinational from state, `cycle_index` and `stall`.
- Reset mid-run: the next cycle is IDLE with all outputs 0. No `done` is emitted.

## Timing
- `start` sampled at edge t. From the cycle after t: RUN, `cycle_valid`=1, `cycle_index`=0.
- With no stalls:
  - RUN lasts N*CPC cycles.
  - DRAIN occupies the next L cycles.
  - `done` is high in the cycle after DRAIN.
  - IDLE follows one cycle later.
- Total `start`-to-`done` latency is N*CPC+L+1 cycles. Each stalled RUN cycle adds exactly 1.
- Output timing:
  - `data_valid` equals `cycle_valid` from exactly L cycles earlier.
  - `data_last` pulses exactly L cycles after the final `last_cycle`, which is the last DRAIN cycle.
- `busy` rises one cycle after an accepted `start` and falls the cycle after `done`.
- `num_inputs`==0 case: `done` is high in the cycle after `start`, and `cycle_valid` and `data_valid` never assert.
- A `start` in the DONE cycle is lost. A `start` in the following IDLE cycle is accepted.

## Test plan
- Reset, then `start` with `num_inputs`=1, defaults:
  - `cycle_index` 0,1,2,3 with `cycle_valid` high for 4 cycles.
  - `first_cycle` high on the first of those cycles; `last_cycle` high on the 4th.
  - `data_valid` follows 2 cycles later; `data_last` pulses on the last DRAIN cycle.
  - `done` pulses 7 cycles after the `start` edge.
- `num_inputs`=3, no stall:
  - 12 valid cycles.
  - `sample_count` steps 0→1→2 at the wraps.
  - `done` at cycle 15 after `start`.
- `num_inputs`=2 with `stall` high for 3 cycles when `cycle_index`==2:
  - `cycle_index` holds at 2 and `cycle_valid` is low for those 3 cycles.
  - `done` at cycle 14 after `start`.
  - Exactly 8 `data_valid` cycles.
- `num_inputs`=0: `done` in the next cycle, no valid asserted, `busy` high for 1 cycle.
- Restart handling, with `num_inputs`=5:
  - `start` pulses during RUN and during the DONE cycle are ignored.
  - `start` in the cycle after `done` launches a new run.
- Assert `reset` during RUN with `sample_count`=1:
  - The next cycle has all outputs 0 and state IDLE.
  - No `done` is emitted.
  - The delay line is cleared, so `data_valid` stays 0.
